vga_timing_gen: RTL and testbench

//  Produces 640x480@60Hz VGA raster timing from the 50 MHz board clock: hsync, vsync, and active-area flag.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing_gen_pix_strobe_div.sv | 43 ++++
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60Hz timing constants, derived sync windows and shared pixel-coordinate types.
package vga_pkg;

    localparam int CLK_DIV  = 2;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    typedef logic [9:0] x_t;
    typedef logic [8:0] y_t;
    typedef logic [9:0] cnt_t;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_strobe_div.sv
// Divides clk_in down to a one-cycle pixel strobe; also exposes the strobe value for the next cycle
// so the parent can register its decodes without adding latency.
module pix_strobe_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic pix_stb,
    output logic pix_stb_nxt
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic          STB_RST  = (CLK_DIV == 1) ? 1'b1 : 1'b0;

    logic [DW-1:0] div_cnt_r;
    logic [DW-1:0] div_nxt_s;

    // Next divider count, wrapping at CLK_DIV-1.
    always_comb begin
        div_nxt_s = div_cnt_r;
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_cnt_r + DIV_ONE;
        end
    end

    assign pix_stb_nxt = (div_nxt_s == DIV_LAST);

    // Divider count and registered strobe; with CLK_DIV==1 the strobe never drops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            pix_stb   <= STB_RST;
        end else begin
            div_cnt_r <= div_nxt_s;
            pix_stb   <= pix_stb_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync, active flag and pixel coordinates.
// Define VGA_SYNC_ALIGN_EN to delay o_hs/o_vs/o_active by one clk_in to match registered colour paths.
module vga_timing_gen #(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clk_in,
    input  logic       i_rst,
    output logic       o_pix_stb,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_active,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_line_end,
    output logic       o_frame_end
);

    import vga_pkg::*;

    localparam cnt_t H_LAST_C   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST_C   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT_C    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C    = cnt_t'(V_ACTIVE);
    localparam cnt_t H_ACT_LAST = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t V_ACT_LAST = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t HS_LO_C    = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_HI_C    = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_LO_C    = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_HI_C    = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam cnt_t CNT_ONE    = cnt_t'(1);

    logic stb_s;
    logic stb_nxt_s;

    cnt_t h_cnt_r;
    cnt_t v_cnt_r;
    cnt_t h_nxt_s;
    cnt_t v_nxt_s;

    logic hs_nxt_s;
    logic vs_nxt_s;
    logic act_nxt_s;
    logic line_nxt_s;
    logic frame_nxt_s;

    logic hs_r;
    logic vs_r;
    logic active_r;
    x_t   x_r;
    y_t   y_r;
    logic line_end_r;
    logic frame_end_r;

    pix_strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_strobe_div (
        .clk_in      (clk_in),
        .rst_n       (i_rst),
        .pix_stb     (stb_s),
        .pix_stb_nxt (stb_nxt_s)
    );

    // Counter next-state: advance h on the strobe, carry into v on the line wrap.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (stb_s) begin
            if (h_cnt_r == H_LAST_C) begin
                h_nxt_s = '0;
                if (v_cnt_r == V_LAST_C) begin
                    v_nxt_s = '0;
                end else begin
                    v_nxt_s = v_cnt_r + CNT_ONE;
                end
            end else begin
                h_nxt_s = h_cnt_r + CNT_ONE;
                v_nxt_s = v_cnt_r;
            end
        end else begin
            h_nxt_s = h_cnt_r;
            v_nxt_s = v_cnt_r;
        end
    end

    // Decode the next counter values so the registered outputs line up with the counters themselves.
    always_comb begin
        hs_nxt_s    = ~in_window(h_nxt_s, HS_LO_C, HS_HI_C);
        vs_nxt_s    = ~in_window(v_nxt_s, VS_LO_C, VS_HI_C);
        act_nxt_s   = (h_nxt_s < H_ACT_C) && (v_nxt_s < V_ACT_C);
        line_nxt_s  = stb_nxt_s && (h_nxt_s == H_LAST_C);
        frame_nxt_s = stb_nxt_s && (h_nxt_s == H_ACT_LAST) && (v_nxt_s == V_ACT_LAST);
    end

    // Raster counters and their registered decodes; reset values match a (0,0) position.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt_r     <= '0;
            v_cnt_r     <= '0;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            active_r    <= 1'b1;
            x_r         <= '0;
            y_r         <= '0;
            line_end_r  <= 1'b0;
            frame_end_r <= 1'b0;
        end else begin
            h_cnt_r     <= h_nxt_s;
            v_cnt_r     <= v_nxt_s;
            hs_r        <= hs_nxt_s;
            vs_r        <= vs_nxt_s;
            active_r    <= act_nxt_s;
            x_r         <= act_nxt_s ? h_nxt_s : 10'd0;
            y_r         <= act_nxt_s ? v_nxt_s[8:0] : 9'd0;
            line_end_r  <= line_nxt_s;
            frame_end_r <= frame_nxt_s;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_dly_r;
    logic vs_dly_r;
    logic active_dly_r;

    // One extra stage on sync/active only; coordinates and pulses stay undelayed.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            hs_dly_r     <= 1'b1;
            vs_dly_r     <= 1'b1;
            active_dly_r <= 1'b0;
        end else begin
            hs_dly_r     <= hs_r;
            vs_dly_r     <= vs_r;
            active_dly_r <= active_r;
        end
    end

    assign o_hs     = hs_dly_r;
    assign o_vs     = vs_dly_r;
    assign o_active = active_dly_r;
`else
    assign o_hs     = hs_r;
    assign o_vs     = vs_r;
    assign o_active = active_r;
`endif

    assign o_pix_stb   = stb_s;
    assign o_x         = x_r;
    assign o_y         = y_r;
    assign o_line_end  = line_end_r;
    assign o_frame_end = frame_end_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 instance plus two shrunken geometries (CLK_DIV 3 and 1)
// compared every cycle against an arithmetic raster model indexed by clk_in edges since reset release.
module tb_vga_timing_gen;

    localparam int NI    = 3;
    localparam int SM_HA = 8;
    localparam int SM_HF = 2;
    localparam int SM_HS = 3;
    localparam int SM_HB = 2;
    localparam int SM_VA = 5;
    localparam int SM_VF = 1;
    localparam int SM_VS = 2;
    localparam int SM_VB = 2;
    localparam int SM_HT = SM_HA + SM_HF + SM_HS + SM_HB;
    localparam int SM_VT = SM_VA + SM_VF + SM_VS + SM_VB;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    longint n     = 0;
    int     compared   = 0;
    int     mismatched = 0;

    logic       stb   [NI];
    logic       hs    [NI];
    logic       vs    [NI];
    logic       act   [NI];
    logic [9:0] xo    [NI];
    logic [8:0] yo    [NI];
    logic       le    [NI];
    logic       fe    [NI];
    logic [24:0] obs  [NI];

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk_in(clk), .i_rst(rst_n), .o_pix_stb(stb[0]), .o_hs(hs[0]), .o_vs(vs[0]),
        .o_active(act[0]), .o_x(xo[0]), .o_y(yo[0]), .o_line_end(le[0]), .o_frame_end(fe[0])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(SM_HA), .H_FP(SM_HF), .H_SYNC(SM_HS), .H_BP(SM_HB),
        .V_ACTIVE(SM_VA), .V_FP(SM_VF), .V_SYNC(SM_VS), .V_BP(SM_VB)
    ) u_small3 (
        .clk_in(clk), .i_rst(rst_n), .o_pix_stb(stb[1]), .o_hs(hs[1]), .o_vs(vs[1]),
        .o_active(act[1]), .o_x(xo[1]), .o_y(yo[1]), .o_line_end(le[1]), .o_frame_end(fe[1])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(SM_HA), .H_FP(SM_HF), .H_SYNC(SM_HS), .H_BP(SM_HB),
        .V_ACTIVE(SM_VA), .V_FP(SM_VF), .V_SYNC(SM_VS), .V_BP(SM_VB)
    ) u_small1 (
        .clk_in(clk), .i_rst(rst_n), .o_pix_stb(stb[2]), .o_hs(hs[2]), .o_vs(vs[2]),
        .o_active(act[2]), .o_x(xo[2]), .o_y(yo[2]), .o_line_end(le[2]), .o_frame_end(fe[2])
    );

    for (genvar g = 0; g < NI; g++) begin : g_obs
        assign obs[g] = {stb[g], hs[g], vs[g], act[g], xo[g], yo[g], le[g], fe[g]};
    end

    // Raster position after n clk_in edges, straight from the timing rules.
    function automatic logic [24:0] raw_model(input int k, input longint cyc);
        longint d, ha, hf, hsw, va, vf, vsw, ht, vt, p, h, v;
        logic s, hsl, vsl, a, l, f;
        logic [9:0] x;
        logic [8:0] y;
        if (k == 0) begin
            d = 2; ha = 640; hf = 16; hsw = 96; va = 480; vf = 10; vsw = 2; ht = 800; vt = 525;
        end else begin
            d = (k == 1) ? 3 : 1;
            ha = SM_HA; hf = SM_HF; hsw = SM_HS; va = SM_VA; vf = SM_VF; vsw = SM_VS;
            ht = SM_HT; vt = SM_VT;
        end
        p   = cyc / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        s   = ((cyc % d) == d - 1);
        hsl = !((h >= ha + hf) && (h < ha + hf + hsw));
        vsl = !((v >= va + vf) && (v < va + vf + vsw));
        a   = (h < ha) && (v < va);
        x   = a ? 10'(h) : 10'd0;
        y   = a ? 9'(v) : 9'd0;
        l   = s && (h == ht - 1);
        f   = s && (h == ha - 1) && (v == va - 1);
        return {s, hsl, vsl, a, x, y, l, f};
    endfunction

    function automatic logic [24:0] exp_vec(input int k, input longint cyc);
        logic [24:0] e;
        e = raw_model(k, cyc);
`ifdef VGA_SYNC_ALIGN_EN
        if (cyc == 0) begin
            e[23:21] = 3'b110;
        end else begin
            logic [24:0] prev;
            prev = raw_model(k, cyc - 1);
            e[23:21] = prev[23:21];
        end
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        n = 0;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            compared++;
            if (obs[k] !== exp_vec(k, 0)) begin
                mismatched++;
                $display("FAIL reset_hold inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k, 0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (stb[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL release_no_stb got=%b exp=0", stb[0]);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            for (int k = 0; k < NI; k++) begin
                compared++;
                if (obs[k] !== exp_vec(k, n)) begin
                    mismatched++;
                    $display("FAIL after_release inst=%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_vec(k, n));
                end
            end
            if (n == 1) begin
                compared++;
                if (stb[0] !== 1'b1) begin
                    mismatched++;
                    $display("FAIL first_stb got=%b exp=1", stb[0]);
                end
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int line_pulses = 0;
        for (int c = 0; c < 1600; c++) begin
            step();
            for (int k = 0; k < NI; k++) begin
                compared++;
                if (obs[k] !== exp_vec(k, n)) begin
                    mismatched++;
                    $display("FAIL line inst=%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_vec(k, n));
                end
            end
            if (hs[0] === 1'b0) hs_low++;
            if (le[0] === 1'b1) line_pulses++;
        end
        compared++;
        if (hs_low != 192) begin
            mismatched++;
            $display("FAIL hs_low_cycles got=%0d exp=192", hs_low);
        end
        compared++;
        if (line_pulses != 1) begin
            mismatched++;
            $display("FAIL line_end_count got=%0d exp=1", line_pulses);
        end
    endtask

    task automatic test_blanking();
        int  found_last = 0;
        int  found_blank = 0;
        longint p;
        for (int c = 0; c < 1000 && (found_last == 0 || found_blank == 0); c++) begin
            step();
            p = n / 3;
            if (found_last == 0 && (p % SM_HT) == SM_HA - 1 && ((p / SM_HT) % SM_VT) == SM_VA - 1) begin
                found_last = 1;
                compared++;
                if (xo[1] !== 10'(SM_HA - 1) || yo[1] !== 9'(SM_VA - 1) || act[1] !== 1'b1) begin
                    mismatched++;
                    $display("FAIL last_pixel got=(%0d,%0d,%b) exp=(%0d,%0d,1)", xo[1], yo[1], act[1], SM_HA - 1, SM_VA - 1);
                end
            end
            if (found_blank == 0 && (n % 3) == 1 && (p % SM_HT) == SM_HA + SM_HF + 1 && ((p / SM_HT) % SM_VT) == 2) begin
                found_blank = 1;
                compared++;
                if (xo[1] !== 10'd0 || yo[1] !== 9'd0 || act[1] !== 1'b0 || hs[1] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL blank_pixel got=(%0d,%0d,%b,hs=%b) exp=(0,0,0,hs=0)", xo[1], yo[1], act[1], hs[1]);
                end
            end
        end
        compared++;
        if (found_last == 0 || found_blank == 0) begin
            mismatched++;
            $display("FAIL blanking_timeout got=%0d%0d exp=11", found_last, found_blank);
        end
    endtask

    task automatic test_frames();
        longint fe_n[$];
        int vs_low1 = 0;
        int vs_low2 = 0;
        for (int c = 0; c < 900; c++) begin
            step();
            for (int k = 0; k < NI; k++) begin
                compared++;
                if (obs[k] !== exp_vec(k, n)) begin
                    mismatched++;
                    $display("FAIL frame inst=%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_vec(k, n));
                end
            end
            if (fe[1] === 1'b1) fe_n.push_back(n);
            if (vs[1] === 1'b0) vs_low1++;
            if (vs[2] === 1'b0) vs_low2++;
        end
        compared++;
        if (fe_n.size() < 2) begin
            mismatched++;
            $display("FAIL frame_end_count got=%0d exp>=2", fe_n.size());
        end
        for (int i = 1; i < fe_n.size(); i++) begin
            compared++;
            if (fe_n[i] - fe_n[i-1] != SM_HT * SM_VT * 3) begin
                mismatched++;
                $display("FAIL frame_period got=%0d exp=%0d", fe_n[i] - fe_n[i-1], SM_HT * SM_VT * 3);
            end
        end
        compared++;
        if (vs_low1 != 2 * SM_VS * SM_HT * 3) begin
            mismatched++;
            $display("FAIL vs_low_div3 got=%0d exp=%0d", vs_low1, 2 * SM_VS * SM_HT * 3);
        end
        compared++;
        if (vs_low2 != 6 * SM_VS * SM_HT) begin
            mismatched++;
            $display("FAIL vs_low_div1 got=%0d exp=%0d", vs_low2, 6 * SM_VS * SM_HT);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 4; r++) begin
            int w;
            w = $urandom_range(3000, 50);
            for (int c = 0; c < w; c++) begin
                step();
                for (int k = 0; k < NI; k++) begin
                    compared++;
                    if (obs[k] !== exp_vec(k, n)) begin
                        mismatched++;
                        $display("FAIL pre_reset inst=%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_vec(k, n));
                    end
                end
            end
            #($urandom_range(6, 1));
            rst_n = 1'b0;
            n = 0;
            #1;
            for (int k = 0; k < NI; k++) begin
                compared++;
                if (obs[k] !== exp_vec(k, 0)) begin
                    mismatched++;
                    $display("FAIL async_reset inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k, 0));
                end
            end
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 200; c++) begin
                step();
                for (int k = 0; k < NI; k++) begin
                    compared++;
                    if (obs[k] !== exp_vec(k, n)) begin
                        mismatched++;
                        $display("FAIL post_reset inst=%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_vec(k, n));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_blanking();
        test_frames();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
